// File: rtl/psram_rr_arb.sv
// ============================================================================
// Module  : psram_rr_arb
// Purpose : Two-master round-robin arbiter with transaction watchdog in front
//           of the single PSRAM native port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module psram_rr_arb #(
  parameter int          TIMEOUT_CYC = 4096,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,

  input  logic        m0_valid_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_wstrb_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ready_o,

  input  logic        m1_valid_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ready_o,

  output logic        mem_valid_o,
  output logic [23:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,

  output logic [1:0]  gnt_o,
  output logic        timeout_o,
  input  logic        timeout_clr_i
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic        WD_EN    = (TIMEOUT_CYC != 0);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_d;
  logic [1:0]  gnt, gnt_d;
  logic        last, last_d;     // 0 = m0 served last, 1 = m1 served last
  logic [15:0] cnt, cnt_d;
  logic        timeout, timeout_d;

  logic        busy;
  logic        done;
  logic        wd_fire;
  logic        finish;
  logic [31:0] resp_data;
  logic        unused_addr_hi;

  assign busy    = (state == BUSY);
  assign done    = busy & mem_ready_i;
  // A real completion in the final watchdog cycle takes precedence.
  assign wd_fire = WD_EN & busy & ~mem_ready_i & (cnt == CNT_LAST);
  assign finish  = done | wd_fire;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      gnt     <= 2'b00;
      last    <= 1'b1;
      cnt     <= 16'd0;
      timeout <= 1'b0;
    end else begin
      state   <= state_d;
      gnt     <= gnt_d;
      last    <= last_d;
      cnt     <= cnt_d;
      timeout <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state;
    gnt_d     = gnt;
    last_d    = last;
    cnt_d     = cnt;
    timeout_d = timeout;

    if (timeout_clr_i) begin
      timeout_d = 1'b0;
    end

    if (state == IDLE) begin
      cnt_d = 16'd0;
      if (m0_valid_i && m1_valid_i) begin
        gnt_d   = last ? 2'b01 : 2'b10;
        state_d = BUSY;
      end else if (m0_valid_i) begin
        gnt_d   = 2'b01;
        state_d = BUSY;
      end else if (m1_valid_i) begin
        gnt_d   = 2'b10;
        state_d = BUSY;
      end
    end else begin
      if (finish) begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        last_d  = gnt[1];
        cnt_d   = 16'd0;
        if (wd_fire) begin
          timeout_d = 1'b1;
        end
      end else begin
        cnt_d = cnt + 16'd1;
      end
    end
  end

  // Request fields follow the grant combinationally; masters hold them stable.
  assign mem_valid_o = busy;
  assign mem_addr_o  = !busy ? 24'd0 : (gnt[1] ? m1_addr_i[23:0] : m0_addr_i[23:0]);
  assign mem_wdata_o = !busy ? 32'd0 : (gnt[1] ? m1_wdata_i : m0_wdata_i);
  assign mem_wstrb_o = !busy ? 4'd0  : (gnt[1] ? m1_wstrb_i : m0_wstrb_i);

  assign resp_data  = mem_ready_i ? mem_rdata_i : ERR_DATA;
  assign m0_ready_o = finish & gnt[0];
  assign m1_ready_o = finish & gnt[1];
  assign m0_rdata_o = m0_ready_o ? resp_data : 32'd0;
  assign m1_rdata_o = m1_ready_o ? resp_data : 32'd0;

  assign gnt_o     = gnt;
  assign timeout_o = timeout;

  // PSRAM space is 16 MiB; upper address bits are intentionally dropped.
  assign unused_addr_hi = ^{m0_addr_i[31:24], m1_addr_i[31:24]};

endmodule

`default_nettype wire

// File: tb/tb_psram_rr_arb.sv
// ============================================================================
// Module  : tb_psram_rr_arb
// Purpose : Directed self-checking bench for psram_rr_arb (TIMEOUT_CYC = 8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psram_rr_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        mem_valid;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [1:0]  gnt;
  logic        timeout;
  logic        timeout_clr;

  int tests = 0;
  int fails = 0;

  psram_rr_arb #(
    .TIMEOUT_CYC (8),
    .ERR_DATA    (32'hDEAD_BEEF)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .m0_valid_i    (m0_valid),
    .m0_addr_i     (m0_addr),
    .m0_wdata_i    (m0_wdata),
    .m0_wstrb_i    (m0_wstrb),
    .m0_rdata_o    (m0_rdata),
    .m0_ready_o    (m0_ready),
    .m1_valid_i    (m1_valid),
    .m1_addr_i     (m1_addr),
    .m1_wdata_i    (m1_wdata),
    .m1_wstrb_i    (m1_wstrb),
    .m1_rdata_o    (m1_rdata),
    .m1_ready_o    (m1_ready),
    .mem_valid_o   (mem_valid),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_wstrb_o   (mem_wstrb),
    .mem_rdata_i   (mem_rdata),
    .mem_ready_i   (mem_ready),
    .gnt_o         (gnt),
    .timeout_o     (timeout),
    .timeout_clr_i (timeout_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    logic [1:0] exp_gnt;

    rst_n = 1'b0;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    mem_rdata = '0; mem_ready = 1'b0; timeout_clr = 1'b0;

    #2;
    chk("rst_gnt",       gnt,       0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_m0_ready",  m0_ready,  0);
    chk("rst_m1_ready",  m1_ready,  0);
    chk("rst_m0_rdata",  m0_rdata,  0);
    chk("rst_timeout",   timeout,   0);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Lone m0 read, completion 3 cycles after mem_valid rises.
    m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wstrb = 4'b0000;
    #1;
    chk("t1_idle_mem_valid", mem_valid, 0);
    chk("t1_idle_gnt",       gnt,       0);
    step();
    chk("t1_busy_mem_valid", mem_valid, 1);
    chk("t1_busy_gnt",       gnt,       32'h1);
    chk("t1_mem_addr",       mem_addr,  32'h0000_0100);
    chk("t1_mem_wstrb",      mem_wstrb, 0);
    chk("t1_early_ready",    m0_ready,  0);
    step(); step(); step();
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    chk("t1_m0_ready",  m0_ready, 1);
    chk("t1_m0_rdata",  m0_rdata, 32'h1234_5678);
    chk("t1_m1_ready",  m1_ready, 0);
    chk("t1_m1_rdata",  m1_rdata, 0);
    step();
    m0_valid = 1'b0; mem_ready = 1'b0;
    #1;
    chk("t1_after_gnt",       gnt,       0);
    chk("t1_after_mem_valid", mem_valid, 0);
    chk("t1_after_m0_ready",  m0_ready,  0);
    chk("t1_after_m0_rdata",  m0_rdata,  0);

    // m1 write.
    m1_valid = 1'b1; m1_addr = 32'h00AB_CDEF; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0011;
    step();
    chk("t3_gnt",       gnt,       32'h2);
    chk("t3_mem_addr",  mem_addr,  32'h00AB_CDEF);
    chk("t3_mem_wdata", mem_wdata, 32'hAABB_CCDD);
    chk("t3_mem_wstrb", mem_wstrb, 32'h3);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0055;
    #1;
    chk("t3_m1_ready", m1_ready, 1);
    chk("t3_m1_rdata", m1_rdata, 32'h0000_0055);
    chk("t3_m0_ready", m0_ready, 0);
    chk("t3_m0_rdata", m0_rdata, 0);
    step();
    m1_valid = 1'b0; mem_ready = 1'b0;
    #1;
    chk("t3_after_m1_ready", m1_ready, 0);

    // Watchdog fires in the 8th BUSY cycle; set beats a same-cycle clear.
    m0_valid = 1'b1; m0_addr = 32'h0000_0200; m0_wstrb = 4'b0000;
    step();
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("t4_no_ready_c%0d", k), m0_ready, 0);
      step();
    end
    timeout_clr = 1'b1;
    #1;
    chk("t4_to_ready",       m0_ready, 1);
    chk("t4_to_rdata",       m0_rdata, 32'hDEAD_BEEF);
    chk("t4_to_flag_before", timeout,  0);
    step();
    m0_valid = 1'b0; timeout_clr = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0000_0099;
    #1;
    chk("t4_flag_set",        timeout,   1);
    chk("t4_late_m0_ready",   m0_ready,  0);
    chk("t4_late_m0_rdata",   m0_rdata,  0);
    chk("t4_late_gnt",        gnt,       0);
    chk("t4_late_mem_valid",  mem_valid, 0);
    step();
    mem_ready = 1'b0;
    #1;
    chk("t4_flag_sticky", timeout, 1);
    timeout_clr = 1'b1;
    step();
    timeout_clr = 1'b0;
    #1;
    chk("t4_flag_cleared", timeout, 0);

    // Completion exactly in the 8th BUSY cycle wins over the watchdog.
    m0_valid = 1'b1;
    step();
    repeat (7) step();
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("t5_ready", m0_ready, 1);
    chk("t5_rdata", m0_rdata, 32'hCAFE_F00D);
    step();
    m0_valid = 1'b0; mem_ready = 1'b0;
    #1;
    chk("t5_no_timeout", timeout, 0);

    // Asynchronous reset in the middle of a BUSY m1 transaction.
    m1_valid = 1'b1;
    step();
    chk("t6_gnt_busy", gnt, 32'h2);
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    #1;
    chk("t6_m1_ready_pre", m1_ready, 1);
    m0_valid = 1'b1; m0_addr = 32'h1100_0010; m1_addr = 32'h2200_0020;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt",       gnt,       0);
    chk("t6_rst_mem_valid", mem_valid, 0);
    chk("t6_rst_m1_ready",  m1_ready,  0);
    chk("t6_rst_m1_rdata",  m1_rdata,  0);
    mem_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("t6_rel_gnt",       gnt,       0);
    chk("t6_rel_mem_valid", mem_valid, 0);

    // Both masters always requesting: grants strictly alternate from m0.
    exp_gnt = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t2_gnt_%0d", i),       gnt,       exp_gnt);
      chk($sformatf("t2_mem_valid_%0d", i), mem_valid, 1);
      chk($sformatf("t2_mem_addr_%0d", i),  mem_addr,
          exp_gnt[0] ? 32'h0000_0010 : 32'h0000_0020);
      mem_ready = 1'b1; mem_rdata = 32'h100 + i;
      #1;
      chk($sformatf("t2_ready_%0d", i), exp_gnt[0] ? m0_ready : m1_ready, 1);
      chk($sformatf("t2_other_ready_%0d", i), exp_gnt[0] ? m1_ready : m0_ready, 0);
      step();
      mem_ready = 1'b0;
      #1;
      chk($sformatf("t2_gap_mem_valid_%0d", i), mem_valid, 0);
      chk($sformatf("t2_gap_gnt_%0d", i),       gnt,       0);
      exp_gnt = ~exp_gnt;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
